// File: rtl/div_seq_if.sv
// Handshake and operand bundle between the E-stage issue logic and the sequential divider.
interface div_seq_if #(
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider (DIV/DIVU), one quotient bit per cycle, result {HI=rem, LO=quo}.
// Define DIV_ZERO_FAST_EN to short-circuit zero divisors through the ZERO state.
module div_seq #(
    parameter int DATA_W = 32
) (
    input logic      clk,
    input logic      rst,
    div_seq_if.slave bus
);
    localparam int              CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ZERO = 2'd1, BUSY = 2'd2, DONE = 2'd3} stateT;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd2, DONE = 2'd3} stateT;
`endif

    stateT state, stateNext;

    logic [CNT_W-1:0]    count;
    logic                signedMode;
    logic                dvdNeg;
    logic                dvsNeg;
    logic [DATA_W-1:0]   quoShift;
    logic [DATA_W-1:0]   divisorMag;
    logic [DATA_W-1:0]   partRem;
    logic [2*DATA_W-1:0] resultReg;

    logic [DATA_W:0]     shiftRem;
    logic [DATA_W:0]     trial;
    logic                qBit;
    logic [DATA_W-1:0]   nextRem;
    logic [DATA_W-1:0]   finalQuo;

    // Two's-complement negate when requested; used both for operand magnitudes and result sign fix.
    function automatic logic [DATA_W-1:0] applySign(input logic [DATA_W-1:0] mag, input logic negate);
        logic signed [DATA_W-1:0] sv;
        sv = $signed(mag);
        return negate ? $unsigned(-sv) : mag;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (bus.annul_i) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
`ifdef DIV_ZERO_FAST_EN
                        stateNext = (bus.opdata2_i == '0) ? ZERO : BUSY;
`else
                        stateNext = BUSY;
`endif
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                ZERO: stateNext = DONE;
`endif
                BUSY: if (count == LAST_ITER) stateNext = DONE;
                DONE: if (!bus.start_i) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ready_o  = (state == DONE);
        bus.busy_o   = (state != IDLE);
        bus.result_o = (state == DONE) ? resultReg : '0;
    end

    // A borrow out of the 33-bit subtract means the shifted remainder is below the divisor,
    // unless the shift already carried into bit DATA_W, which no 32-bit divisor can exceed.
    always_comb begin
        shiftRem = {partRem, quoShift[DATA_W-1]};
        trial    = shiftRem - {1'b0, divisorMag};
        qBit     = shiftRem[DATA_W] | ~trial[DATA_W];
        nextRem  = qBit ? trial[DATA_W-1:0] : shiftRem[DATA_W-1:0];
        finalQuo = {quoShift[DATA_W-2:0], qBit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            signedMode <= 1'b0;
            dvdNeg     <= 1'b0;
            dvsNeg     <= 1'b0;
            quoShift   <= '0;
            divisorMag <= '0;
            partRem    <= '0;
            resultReg  <= '0;
        end else if (!bus.annul_i) begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        signedMode <= bus.signed_i;
                        dvdNeg     <= bus.opdata1_i[DATA_W-1];
                        dvsNeg     <= bus.opdata2_i[DATA_W-1];
                        quoShift   <= applySign(bus.opdata1_i, bus.signed_i & bus.opdata1_i[DATA_W-1]);
                        divisorMag <= applySign(bus.opdata2_i, bus.signed_i & bus.opdata2_i[DATA_W-1]);
                        partRem    <= '0;
                        count      <= '0;
                        resultReg  <= '0;
                    end
                end
                BUSY: begin
                    partRem  <= nextRem;
                    quoShift <= finalQuo;
                    count    <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        resultReg <= {applySign(nextRem, signedMode & dvdNeg),
                                      applySign(finalQuo, signedMode & (dvdNeg ^ dvsNeg))};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scenario tasks push expected results to a scoreboard queue.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_seq_if #(.DATA_W(32)) bus();
    div_seq #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [63:0] expQ[$];

`ifdef DIV_ZERO_FAST_EN
    localparam int          ZERO_LAT = 2;
    localparam logic [63:0] ZERO_RES = 64'h0;
`else
    localparam int          ZERO_LAT = 33;
    localparam logic [63:0] ZERO_RES = {32'h5, 32'hFFFF_FFFF};
`endif

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'h0) begin
`ifdef DIV_ZERO_FAST_EN
            return 64'h0;
`else
            return {a, (s && a[31]) ? 32'h1 : 32'hFFFF_FFFF};
`endif
        end
        sa = s ? longint'($signed(a)) : longint'({32'h0, a});
        sb = s ? longint'($signed(b)) : longint'({32'h0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] exp);
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.signed_i  = s;
        bus.start_i   = 1'b1;
        expQ.push_back(exp);
    endtask

    task automatic wait_ready(input int maxc, output int lat, output bit leak);
        lat  = -1;
        leak = 1'b0;
        for (int n = 1; n <= maxc; n++) begin
            tick();
            if (bus.ready_o === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.result_o !== 64'h0) leak = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue(32'd77, 32'd3, 1'b0, 64'h0);
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        tick();
        void'(expQ.pop_front());
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        checks++; if (bus.result_o !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
        rst = 1'b0;
        bus.start_i = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int lat; bit leak; logic [63:0] exp;
        issue(32'd100, 32'd7, 1'b0, {32'h2, 32'hE});
        tick();
        checks++; if (bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0) begin errors++; $display("FAIL unsigned_busy: got busy=%b ready=%b expected busy=1 ready=0", bus.busy_o, bus.ready_o); end
        wait_ready(40, lat, leak);
        exp = expQ.pop_front();
        checks++; if (lat + 1 != 33) begin errors++; $display("FAIL unsigned_latency: got %0d expected 33", lat + 1); end
        checks++; if (leak) begin errors++; $display("FAIL unsigned_leak: got nonzero result before ready expected 0"); end
        checks++; if (bus.result_o !== exp) begin errors++; $display("FAIL unsigned_result: got %h expected %h", bus.result_o, exp); end
        for (int k = 0; k < 3; k++) begin
            bus.opdata1_i = 32'hDEAD_0000 + k;
            tick();
            checks++; if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin errors++; $display("FAIL unsigned_hold%0d: got ready=%b res=%h expected ready=1 res=%h", k, bus.ready_o, bus.result_o, exp); end
        end
        bus.start_i = 1'b0;
        tick();
        checks++; if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 64'h0) begin errors++; $display("FAIL unsigned_release: got ready=%b busy=%b res=%h expected 0 0 0", bus.ready_o, bus.busy_o, bus.result_o); end
    endtask

    task automatic test_signed();
        logic [31:0] ta [5] = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFF9};
        logic [31:0] tb [5] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd2};
        logic        ts [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] te [5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h1, 32'hFFFF_FFFD},
                               {32'h0, 32'h8000_0000},        {32'hFFFF_FFFE, 32'hE},
                               {32'h1, 32'h7FFF_FFFC}};
        int lat; bit leak; logic [63:0] exp;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], ts[i], te[i]);
            wait_ready(40, lat, leak);
            exp = expQ.pop_front();
            checks++; if (lat != 33) begin errors++; $display("FAIL signed%0d_latency: got %0d expected 33", i, lat); end
            checks++; if (bus.result_o !== exp) begin errors++; $display("FAIL signed%0d_result: got %h expected %h", i, bus.result_o, exp); end
            bus.start_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_div_zero();
        int lat; bit leak; logic [63:0] exp;
        issue(32'd5, 32'd0, 1'b0, ZERO_RES);
        wait_ready(40, lat, leak);
        exp = expQ.pop_front();
        checks++; if (lat != ZERO_LAT) begin errors++; $display("FAIL divzero_latency: got %0d expected %0d", lat, ZERO_LAT); end
        checks++; if (bus.result_o !== exp) begin errors++; $display("FAIL divzero_result: got %h expected %h", bus.result_o, exp); end
        bus.start_i = 1'b0;
        tick();
        checks++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin errors++; $display("FAIL divzero_release: got ready=%b res=%h expected 0 0", bus.ready_o, bus.result_o); end
    endtask

    task automatic test_annul();
        int lat; bit leak; logic [63:0] exp;
        issue(32'd1000, 32'd3, 1'b0, model(32'd1000, 32'd3, 1'b0));
        for (int k = 0; k < 10; k++) tick();
        bus.annul_i = 1'b1;
        tick();
        void'(expQ.pop_front());
        checks++; if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 64'h0) begin errors++; $display("FAIL annul_idle: got ready=%b busy=%b res=%h expected 0 0 0", bus.ready_o, bus.busy_o, bus.result_o); end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        tick();
        issue(32'd9, 32'd3, 1'b0, {32'h0, 32'h3});
        wait_ready(40, lat, leak);
        exp = expQ.pop_front();
        checks++; if (lat != 33) begin errors++; $display("FAIL annul_restart_latency: got %0d expected 33", lat); end
        checks++; if (bus.result_o !== exp) begin errors++; $display("FAIL annul_restart_result: got %h expected %h", bus.result_o, exp); end
        bus.start_i = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid_busy();
        int lat; bit leak; logic [63:0] exp;
        issue(32'd50, 32'd5, 1'b0, {32'h0, 32'hA});
        for (int k = 0; k < 20; k++) tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 64'h0) begin errors++; $display("FAIL rst_mid_outputs: got ready=%b busy=%b res=%h expected 0 0 0", bus.ready_o, bus.busy_o, bus.result_o); end
        rst = 1'b0;
        wait_ready(40, lat, leak);
        exp = expQ.pop_front();
        checks++; if (lat != 33) begin errors++; $display("FAIL rst_mid_latency: got %0d expected 33", lat); end
        checks++; if (bus.result_o !== exp) begin errors++; $display("FAIL rst_mid_result: got %h expected %h", bus.result_o, exp); end
        bus.start_i = 1'b0;
        tick();
    endtask

    task automatic test_operand_change();
        int lat; bit leak; logic [63:0] exp;
        issue(32'd1000, 32'd7, 1'b0, {32'd6, 32'd142});
        tick();
        bus.opdata1_i = 32'hFFFF_FFFF;
        bus.opdata2_i = 32'h0;
        bus.signed_i  = 1'b1;
        wait_ready(40, lat, leak);
        exp = expQ.pop_front();
        checks++; if (lat + 1 != 33) begin errors++; $display("FAIL opchange_latency: got %0d expected 33", lat + 1); end
        checks++; if (bus.result_o !== exp) begin errors++; $display("FAIL opchange_result: got %h expected %h", bus.result_o, exp); end
        bus.start_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat; bit leak; logic [63:0] exp;
        logic [31:0] a, b; logic s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if (b == 32'h0) b = 32'h1;
            s = 1'($urandom_range(0, 1));
            issue(a, b, s, model(a, b, s));
            wait_ready(40, lat, leak);
            exp = expQ.pop_front();
            checks++; if (lat != 33) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected 33", i, lat); end
            checks++; if (bus.result_o !== exp) begin errors++; $display("FAIL b2b%0d_result: a=%h b=%h s=%b got %h expected %h", i, a, b, s, bus.result_o, exp); end
            bus.start_i = 1'b0;
            tick();
            checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL b2b%0d_release: got %b expected 0", i, bus.ready_o); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.annul_i   = 1'b0;
        tick();
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_rst_mid_busy();
        test_operand_change();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
